aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Sequences one AES-128 block encryption over an external SubBytes unit (i_en/o_en handshake, 128-bit).
//  Owns state register, round counter, ShiftRows/MixColumns, AddRoundKey; fetches round keys from key schedule.
//  Sits between the block-level start/done interface and the shared S-box datapath.
// PARAMETERS
//  NR           10   number of rounds (AES-128)
//  SUB_TIMEOUT  64   max cycles to wait for sub_valid before aborting; counter width $clog2(SUB_TIMEOUT+1)
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-low reset
//  start      in   1    request encryption of data_in; accepted only when ready=1
//  data_in    in   128  plaintext; bits[127:120]=byte 0, FIPS-197 column-major
//  ready      out  1    1 in IDLE only
//  data_out   out  128  ciphertext; valid when done=1, held until next accepted start
//  done       out  1    one-cycle pulse, block complete
//  err        out  1    one-cycle pulse, SubBytes timeout abort
//  sub_data   out  128  state to SubBytes unit; stable while sub_en=1
//  sub_en     out  1    SubBytes request; held high until sub_valid
//  sub_result in   128  SubBytes output; sampled when sub_valid=1
//  sub_valid  in   1    SubBytes complete (o_en of the S-box unit)
//  rk_req     out  1    round-key request; held high until rk_valid
//  rk_idx     out  4    round-key index 0..NR
//  rk_data    in   128  round key; sampled when rk_valid & rk_req
//  rk_valid   in   1    round key available; same-cycle-as-rk_req acceptance allowed
// BEHAVIOUR
//  Reset (rst=0, async): FSM->IDLE, round=0, state=0, data_out=0, done=err=sub_en=rk_req=0, rk_idx=0, sub_data=0.
//  FSM: IDLE, KEY, SUB, MIX, DONE.
//   IDLE: ready=1. start -> state<=data_in, round<=0, ->KEY. start in any other state ignored.
//   KEY : rk_req=1, rk_idx=round. On rk_valid: state<=state^rk_data;
//         round==NR -> DONE; else round<=round+1, ->SUB. No rk_valid: stay.
//   SUB : sub_en=1, sub_data=state; timeout counter increments per cycle.
//         sub_valid -> state<=sub_result, ->MIX; sub_en low next cycle.
//         counter reaches SUB_TIMEOUT w/o sub_valid -> err pulse, ->IDLE, data_out unchanged.
//   MIX : 1 cycle. round==NR: state<=shift_rows(state); else state<=mix_columns(shift_rows(state)). ->KEY.
//   DONE: data_out<=state, done=1 for this cycle, ->IDLE.
//  sub_valid/rk_valid outside SUB/KEY: ignored.
//  MixColumns over GF(2^8), poly 0x11B, xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
//  Latency: key returned same cycle, S-box latency L (L>=1 cycles, sub_en rise to sub_valid):
//   start accepted cycle 0, done at cycle 2+10*(L+2); L=1 -> cycle 32.
//  Reset mid-block: immediate abort, no done/err, outputs to reset values.
//  round counter never exceeds NR; rk_idx sequence exactly 0,1,..,NR per block.
// STRUCTURE
//  aes_pkg: NR_AES128 constant, ctrl_state_e enum, functions xtime, shift_rows, mix_columns (128-bit in/out).
//  Sub-module: aes_shift_mix (combinational; inputs state, last_round; output next state) for MIX step.
//  S-box unit and key schedule stay external; this block holds no S-box tables.
// TESTING
//  FIPS-197 App.B: data_in=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c
//   -> data_out=3925841d02dc09fbdc118597196a0b32, one done pulse, rk_idx 0..10 in order.
//  Same vector, first sub_data must be 193de3bea0f4e22b9ac68d2ae9f84808;
//   first state after SUB = d42711aee0bf98f1b8b45de51e415230.
//  Bench S-box model L=1, rk_valid same cycle -> done exactly at cycle 32; L=3 -> cycle 52.
//  rk_valid delayed 5 cycles each round -> same ciphertext, rk_req held, sub_en low meanwhile.
//  sub_valid never asserted -> err pulse at SUB_TIMEOUT cycles in SUB, ready=1 next cycle, no done.
//  rst low during round 5, start pulses while busy -> outputs reset at once, later start ignored;
//   new block after reset gives correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : AES-128 round-controller types and GF(2^8) round helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_SUB  = 3'd2,
        ST_MIX  = 3'd3,
        ST_DONE = 3'd4
    } ctrl_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Byte k of the state lives at bits [127-8k -: 8]; k = row + 4*column.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_shift_mix.sv
`default_nettype none
// ============================================================================
// Module      : aes_shift_mix
// Description : Combinational ShiftRows + MixColumns; MixColumns skipped in the last round.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_shift_mix
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic         last_round,
    output logic [127:0] state_out
);

    logic [127:0] w_shifted;

    assign w_shifted = shift_rows(state_in);
    assign state_out = last_round ? w_shifted : mix_columns(w_shifted);

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : Sequences one AES-128 encryption over an external S-box unit and key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR          = NR_AES128,
    parameter int SUB_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic         ready,
    output logic [127:0] data_out,
    output logic         done,
    output logic         err,
    output logic [127:0] sub_data,
    output logic         sub_en,
    input  logic [127:0] sub_result,
    input  logic         sub_valid,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    input  logic         rk_valid
);

    localparam int               TMO_W        = $clog2(SUB_TIMEOUT + 1);
    localparam logic [3:0]       C_ROUND_LAST = 4'(NR);
    localparam logic [TMO_W-1:0] C_TMO_LAST   = TMO_W'(SUB_TIMEOUT - 1);

    ctrl_state_e      r_fsm;
    ctrl_state_e      w_fsm_next;
    logic [127:0]     r_state;
    logic [3:0]       r_round;
    logic [TMO_W-1:0] r_tmo;
    logic [127:0]     r_data_out;
    logic [127:0]     w_mix_out;
    logic             w_last_round;
    logic             w_tmo_expired;

    assign w_last_round  = (r_round == C_ROUND_LAST);
    assign w_tmo_expired = (r_tmo == C_TMO_LAST);

    aes_shift_mix u_shift_mix (
        .state_in   (r_state),
        .last_round (w_last_round),
        .state_out  (w_mix_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE: if (start)     w_fsm_next = ST_KEY;
            ST_KEY:  if (rk_valid)  w_fsm_next = w_last_round ? ST_DONE : ST_SUB;
            ST_SUB: begin
                if (sub_valid)          w_fsm_next = ST_MIX;
                else if (w_tmo_expired) w_fsm_next = ST_IDLE;
            end
            ST_MIX:  w_fsm_next = ST_KEY;
            ST_DONE: w_fsm_next = ST_IDLE;
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready    = (r_fsm == ST_IDLE);
        rk_req   = (r_fsm == ST_KEY);
        sub_en   = (r_fsm == ST_SUB);
        done     = (r_fsm == ST_DONE);
        err      = (r_fsm == ST_SUB) && !sub_valid && w_tmo_expired;
        sub_data = (r_fsm == ST_SUB) ? r_state : '0;
        rk_idx   = r_round;
        data_out = r_data_out;
    end

    // Ciphertext is captured on the final key add so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= '0;
            r_round    <= '0;
            r_tmo      <= '0;
            r_data_out <= '0;
        end else begin
            r_tmo <= (r_fsm == ST_SUB) ? r_tmo + 1'b1 : '0;
            case (r_fsm)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= data_in;
                        r_round <= '0;
                    end
                end
                ST_KEY: begin
                    if (rk_valid) begin
                        r_state <= r_state ^ rk_data;
                        if (w_last_round) begin
                            r_data_out <= r_state ^ rk_data;
                        end else begin
                            r_round <= r_round + 1'b1;
                        end
                    end
                end
                ST_SUB: begin
                    if (sub_valid) begin
                        r_state <= sub_result;
                    end
                end
                ST_MIX: begin
                    r_state <= w_mix_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Directed FIPS-197 vectors against aes_round_ctrl with S-box and key-schedule models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] data_in = '0;
    logic         ready, done, err, sub_en, rk_req, sub_valid, rk_valid;
    logic [127:0] data_out, sub_data, sub_result, rk_data;
    logic [3:0]   rk_idx;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk_tab [11];
    int           sub_lat = 1;
    int           key_dly = 0;
    bit           sbox_on = 1'b1;
    int           sub_cnt;
    int           key_cnt;
    logic [3:0]   idx_log [$];
    logic [127:0] sub_log [$];

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .SUB_TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .ready      (ready),
        .data_out   (data_out),
        .done       (done),
        .err        (err),
        .sub_data   (sub_data),
        .sub_en     (sub_en),
        .sub_result (sub_result),
        .sub_valid  (sub_valid),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .rk_valid   (rk_valid)
    );

    // Responders: count cycles of each request to place the answer L / delay cycles in.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_cnt <= 0;
            key_cnt <= 0;
        end else begin
            sub_cnt <= sub_en ? sub_cnt + 1 : 0;
            key_cnt <= rk_req ? key_cnt + 1 : 0;
        end
    end

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
        return o;
    endfunction

    assign sub_valid  = sbox_on && sub_en && (sub_cnt == sub_lat - 1);
    assign sub_result = sub_bytes(sub_data);
    assign rk_valid   = rk_req && (key_cnt == key_dly);
    assign rk_data    = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x   = 8'(v);
            inv = '0;
            for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Runs one block; cycle 1 is the first cycle after the edge that accepts start.
    task automatic run_block(input logic [127:0] pt, input int inj_cyc, input int max_cyc,
                             output int done_at, output int ndone, output int nerr,
                             output int viol, output logic busy_ready, output logic [127:0] ct);
        int   cyc;
        logic prev_req, prev_valid;
        idx_log.delete();
        sub_log.delete();
        done_at = -1; ndone = 0; nerr = 0; viol = 0; ct = '0;
        prev_req = 1'b0; prev_valid = 1'b0;
        @(negedge clk);
        data_in = pt;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ready = ready;
        cyc = 1;
        while (cyc <= max_cyc && (done_at < 0 || cyc < done_at + 3)) begin
            if (rk_req && rk_valid) idx_log.push_back(rk_idx);
            if (sub_en && sub_cnt == 0) sub_log.push_back(sub_data);
            if (rk_req && sub_en) viol++;
            if (prev_req && !prev_valid && !rk_req) viol++;
            prev_req   = rk_req;
            prev_valid = rk_valid;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = cyc;
                    ct      = data_out;
                end
            end
            if (err) nerr++;
            if (cyc == inj_cyc) begin
                start   = 1'b1;
                data_in = ~pt;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || sub_en !== 1'b0 || rk_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b done=%b err=%b sub_en=%b rk_req=%b, expected 1 0 0 0 0",
                     ready, done, err, sub_en, rk_req);
        end
        checks++;
        if (data_out !== '0 || sub_data !== '0 || rk_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: data_out=%h sub_data=%h rk_idx=%0d, expected all zero",
                     data_out, sub_data, rk_idx);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fips_b();
        int done_at, ndone, nerr, viol;
        logic busy_ready;
        logic [127:0] ct;
        bit seq_ok;
        expand_key(KEY_B);
        sub_lat = 1; key_dly = 0; sbox_on = 1'b1;
        run_block(PT_B, -1, 200, done_at, ndone, nerr, viol, busy_ready, ct);
        checks++;
        if (ct !== CT_B) begin errors++; $display("FAIL fips_b_ct: got %h, expected %h", ct, CT_B); end
        checks++;
        if (done_at !== 32) begin errors++; $display("FAIL fips_b_latency: done at cycle %0d, expected 32", done_at); end
        checks++;
        if (ndone !== 1 || nerr !== 0) begin
            errors++; $display("FAIL fips_b_pulses: done=%0d err=%0d, expected 1 and 0", ndone, nerr);
        end
        checks++;
        if (busy_ready !== 1'b0) begin errors++; $display("FAIL fips_b_busy_ready: got %b, expected 0", busy_ready); end
        seq_ok = (idx_log.size() == 11);
        for (int i = 0; i < idx_log.size(); i++) if (idx_log[i] !== 4'(i)) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin errors++; $display("FAIL fips_b_rk_idx: %0d keys fetched or out of order, expected 0..10", idx_log.size()); end
        checks++;
        if (sub_log.size() < 2 || sub_log[0] !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
            errors++; $display("FAIL fips_b_sub0: got %h, expected 193de3bea0f4e22b9ac68d2ae9f84808",
                               (sub_log.size() > 0) ? sub_log[0] : 128'h0);
        end
        checks++;
        if (sub_log.size() < 2 || sub_log[1] !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
            errors++; $display("FAIL fips_b_sub1: got %h, expected a49c7ff2689f352b6b5bea43026a5049",
                               (sub_log.size() > 1) ? sub_log[1] : 128'h0);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || data_out !== CT_B) begin
            errors++; $display("FAIL fips_b_hold: ready=%b data_out=%h, expected 1 and %h", ready, data_out, CT_B);
        end
    endtask

    task automatic test_latency3();
        int done_at, ndone, nerr, viol;
        logic busy_ready;
        logic [127:0] ct;
        expand_key(KEY_C);
        sub_lat = 3; key_dly = 0; sbox_on = 1'b1;
        run_block(PT_C, -1, 300, done_at, ndone, nerr, viol, busy_ready, ct);
        checks++;
        if (ct !== CT_C) begin errors++; $display("FAIL lat3_ct: got %h, expected %h", ct, CT_C); end
        checks++;
        if (done_at !== 52 || ndone !== 1) begin
            errors++; $display("FAIL lat3_latency: done at %0d (%0d pulses), expected cycle 52, 1 pulse", done_at, ndone);
        end
    endtask

    task automatic test_key_delay();
        int done_at, ndone, nerr, viol;
        logic busy_ready;
        logic [127:0] ct;
        bit seq_ok;
        expand_key(KEY_B);
        sub_lat = 1; key_dly = 5; sbox_on = 1'b1;
        run_block(PT_B, 10, 400, done_at, ndone, nerr, viol, busy_ready, ct);
        checks++;
        if (ct !== CT_B || ndone !== 1) begin
            errors++; $display("FAIL keydly_ct: got %h (%0d done), expected %h once", ct, ndone, CT_B);
        end
        checks++;
        if (done_at !== 87) begin errors++; $display("FAIL keydly_latency: done at %0d, expected 87", done_at); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL keydly_handshake: %0d violations, expected 0", viol); end
        seq_ok = (idx_log.size() == 11);
        for (int i = 0; i < idx_log.size(); i++) if (idx_log[i] !== 4'(i)) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin errors++; $display("FAIL keydly_rk_idx: %0d keys fetched or out of order, expected 0..10", idx_log.size()); end
        key_dly = 0;
    endtask

    task automatic test_timeout();
        int  nsub, err_at;
        bit  saw_done;
        logic [127:0] prev_out;
        prev_out = data_out;
        sbox_on  = 1'b0;
        nsub = 0; err_at = -1; saw_done = 1'b0;
        @(negedge clk);
        data_in = PT_B;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (sub_en) nsub++;
            if (done) saw_done = 1'b1;
            if (err) begin
                err_at = nsub;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (err_at !== 64) begin errors++; $display("FAIL timeout_err: err after %0d SUB cycles, expected 64", err_at); end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || err !== 1'b0 || sub_en !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: ready=%b err=%b sub_en=%b, expected 1 0 0", ready, err, sub_en);
        end
        checks++;
        if (saw_done || data_out !== prev_out) begin
            errors++; $display("FAIL timeout_out: done_seen=%b data_out=%h, expected 0 and %h", saw_done, data_out, prev_out);
        end
        sbox_on = 1'b1;
    endtask

    task automatic test_reset_mid();
        int done_at, ndone, nerr, viol;
        logic busy_ready;
        logic [127:0] ct;
        bit found, stray;
        expand_key(KEY_B);
        sub_lat = 1; key_dly = 0; sbox_on = 1'b1;
        found = 1'b0; stray = 1'b0;
        @(negedge clk);
        data_in = PT_B;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 200; c++) begin
            if (rk_req && rk_idx == 4'd5) begin
                found = 1'b1;
                break;
            end
            start   = (c == 10);
            data_in = (c == 10) ? '1 : PT_B;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_reach: round 5 key fetch not seen, expected it"); end
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || rk_req !== 1'b0 || sub_en !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: ready=%b rk_req=%b sub_en=%b done=%b err=%b, expected 1 0 0 0 0",
                               ready, rk_req, sub_en, done, err);
        end
        checks++;
        if (data_out !== '0 || rk_idx !== 4'd0 || sub_data !== '0) begin
            errors++; $display("FAIL rstmid_data: data_out=%h rk_idx=%0d sub_data=%h, expected zeros", data_out, rk_idx, sub_data);
        end
        start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || err || !ready) stray = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (stray || ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: stray=%b ready=%b done=%b, expected 0 1 0", stray, ready, done);
        end
        run_block(PT_B, -1, 200, done_at, ndone, nerr, viol, busy_ready, ct);
        checks++;
        if (ct !== CT_B || done_at !== 32 || ndone !== 1) begin
            errors++; $display("FAIL rstmid_rerun: ct=%h at cycle %0d (%0d done), expected %h at 32 once",
                               ct, done_at, ndone, CT_B);
        end
    endtask

    initial begin
        build_sbox();
        expand_key(KEY_B);
        test_reset();
        test_fips_b();
        test_latency3();
        test_key_delay();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
